// File: rtl/sram_like_inst_responder_pkg.sv
// Shared encodings, request payload layout and address helper for the SRAM-like responder.
package sram_like_inst_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    // {wr, size, addr, wstrb, wdata}
    localparam int unsigned REQ_W = 1 + 2 + ADDR_W + STRB_W + DATA_W;

    localparam logic [ADDR_W-1:0] DEFAULT_BASE = 32'h1C00_0000;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

    // Word offset of a byte address relative to the mapped base; caller truncates to array size.
    function automatic logic [ADDR_W-1:0] word_offset(input logic [ADDR_W-1:0] addr,
                                                      input logic [ADDR_W-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_like_inst_responder_if.sv
// SRAM-like request/response bus between an initiator and the responder.
interface sram_like_inst_responder_if;
    import sram_like_inst_responder_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;
    logic              resp_hold;
    logic [3:0]        outstanding;

    modport master (
        output req, wr, size, addr, wstrb, wdata, resp_hold,
        input  addr_ok, data_ok, rdata, outstanding
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata, resp_hold,
        output addr_ok, data_ok, rdata, outstanding
    );

endinterface

// File: rtl/sram_like_inst_responder_resp_fifo.sv
// In-order response queue; every entry carries a countdown that ages in parallel with the others.
module sram_like_inst_responder_resp_fifo
    import sram_like_inst_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  logic                        push_is_wr,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic                        head_ready,
    output logic                        head_is_wr,
    output logic [DATA_W-1:0]           head_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef struct packed {
        logic              is_wr;
        logic [DATA_W-1:0] data;
        logic [TW-1:0]     timer;
    } entry_t;

    entry_t        ents [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage: the slot being written loads, every other slot counts down towards zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && (wptr == PW'(i))) begin
                ents[i] <= '{is_wr: push_is_wr, data: push_data, timer: TW'(LATENCY - 1)};
            end else if (ents[i].timer != '0) begin
                ents[i].timer <= ents[i].timer - TW'(1);
            end
        end
    end

    // Head may retire on the edge where its countdown reaches (or already sits at) zero.
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head_ready = !empty && (ents[rptr].timer <= TW'(1));
    assign head_is_wr = ents[rptr].is_wr;
    assign head_data  = ents[rptr].data;

endmodule

// File: rtl/sram_like_inst_responder.sv
// SRAM-like slave: word-array backed, accepts up to DEPTH requests, answers in order after LATENCY.
module sram_like_inst_responder
    import sram_like_inst_responder_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       LATENCY   = 2,
    parameter int unsigned       MEM_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE      = DEFAULT_BASE
) (
    input  logic                       clk,
    input  logic                       resetn,
    sram_like_inst_responder_if.slave  bus
);

    localparam int unsigned AW     = $clog2(MEM_WORDS);
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam bit          BYPASS = (LATENCY == 1);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    sram_req_t         req_c;
    logic [AW-1:0]     idx_c;
    logic [DATA_W-1:0] rd_word_c;
    logic              handshake_c;
    logic              bypass_c;
    logic              push_c;
    logic              pop_c;
    logic              size_unused;

    logic              fifo_ready;
    logic              fifo_is_wr;
    logic [DATA_W-1:0] fifo_data;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic              data_ok_q;
    logic [DATA_W-1:0] rdata_q;

    assign req_c = '{wr: bus.wr, size: bus.size, addr: bus.addr, wstrb: bus.wstrb, wdata: bus.wdata};
    assign size_unused = ^req_c.size;

    // No bypass when full: a retire in the same cycle does not open a slot until the next cycle.
    assign bus.addr_ok  = bus.req && resetn && !fifo_full;
    assign handshake_c  = bus.req && bus.addr_ok;
    assign idx_c        = AW'(word_offset(req_c.addr, BASE));
    assign rd_word_c    = mem[idx_c];

    // With unit latency an access into an empty queue answers straight from the accept edge.
    assign bypass_c = BYPASS && handshake_c && fifo_empty && !bus.resp_hold;
    assign push_c   = handshake_c && !bypass_c;
    assign pop_c    = fifo_ready && !bus.resp_hold;

    // Byte-enabled write at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (handshake_c && req_c.wr) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (req_c.wstrb[b]) mem[idx_c][8*b +: 8] <= req_c.wdata[8*b +: 8];
            end
        end
    end

    sram_like_inst_responder_resp_fifo #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (push_c),
        .push_is_wr (req_c.wr),
        .push_data  (rd_word_c),
        .pop        (pop_c),
        .head_ready (fifo_ready),
        .head_is_wr (fifo_is_wr),
        .head_data  (fifo_data),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Response register: one data_ok pulse per retired entry, rdata zero otherwise and for writes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end else if (pop_c) begin
            data_ok_q <= 1'b1;
            rdata_q   <= fifo_is_wr ? '0 : fifo_data;
        end else if (bypass_c) begin
            data_ok_q <= 1'b1;
            rdata_q   <= req_c.wr ? '0 : rd_word_c;
        end else begin
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
        end
    end

    assign bus.data_ok     = data_ok_q;
    assign bus.rdata       = rdata_q;
    assign bus.outstanding = 4'(fifo_count);

endmodule
